// File: rtl/l2_tag_controller.sv
// Direct-mapped L2 tag controller: 16 lines x 64 B, write-back with a single outstanding loader trigger.
// Optional hit/miss statistics counters are built when L2_TAG_STATS_EN is defined.
module l2_tag_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    output logic        ack,
    output logic [7:0]  hit_group,
    output logic        busy,
    output logic        err,
    output logic        ld_rtrig,
    output logic        ld_wtrig,
    output logic [31:0] ld_addr,
    output logic [7:0]  ld_group,
    input  logic        ld_finish,
    input  logic        ld_fault,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        RF_REQ,
        RF_WAIT,
        UPDATE,
        RESP,
        ERR
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] addr_q;
    logic        we_q;

    logic [15:0] valid;
    logic [15:0] dirty;
    logic [21:0] tag_mem [16];

    logic [3:0]  line_idx;
    logic [21:0] line_tag;
    logic        lookup_hit;
    logic        victim_dirty;
    logic        fault_abort;

    assign line_idx = addr_q[9:6];
    assign line_tag = addr_q[31:10];

    always_comb begin
        lookup_hit   = valid[line_idx] && (tag_mem[line_idx] == line_tag);
        victim_dirty = valid[line_idx] && dirty[line_idx];
        fault_abort  = ld_fault && (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ack        = 1'b0;
        ld_wtrig   = 1'b0;
        ld_rtrig   = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (req) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    next_state = RESP;
                end else if (victim_dirty) begin
                    next_state = WB_REQ;
                end else begin
                    next_state = RF_REQ;
                end
            end
            WB_REQ: begin
                ld_wtrig   = 1'b1;
                next_state = WB_WAIT;
            end
            WB_WAIT: begin
                if (ld_finish) begin
                    next_state = RF_REQ;
                end
            end
            RF_REQ: begin
                ld_rtrig   = 1'b1;
                next_state = RF_WAIT;
            end
            RF_WAIT: begin
                if (ld_finish) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                next_state = RESP;
            end
            RESP: begin
                ack        = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // A loader fault overrides every other transition, including from ERR itself
        if (fault_abort) begin
            next_state = ERR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            hit_group <= '0;
            ld_addr   <= '0;
            ld_group  <= '0;
            err       <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                addr_q    <= addr;
                we_q      <= we;
                hit_group <= addr[9:2];
            end
            if (fault_abort) begin
                err <= 1'b1;
            end else begin
                // Loader address is set up one cycle ahead so it is valid in the trigger cycle
                if (state == LOOKUP && !lookup_hit) begin
                    ld_group <= {line_idx, 4'h0};
                    if (victim_dirty) begin
                        ld_addr <= {tag_mem[line_idx], line_idx, 6'h0};
                    end else begin
                        ld_addr <= {addr_q[31:6], 6'h0};
                    end
                end
                if (state == WB_WAIT && ld_finish) begin
                    ld_addr <= {addr_q[31:6], 6'h0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            dirty <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (!fault_abort) begin
            if (state == LOOKUP && lookup_hit && we_q) begin
                dirty[line_idx] <= 1'b1;
            end
            if (state == WB_WAIT && ld_finish) begin
                dirty[line_idx] <= 1'b0;
            end
            if (state == UPDATE) begin
                tag_mem[line_idx] <= line_tag;
                valid[line_idx]   <= 1'b1;
                dirty[line_idx]   <= we_q;
            end
        end
    end

`ifdef L2_TAG_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !fault_abort) begin
            if (lookup_hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_tag_controller.sv
// Randomized self-checking bench for l2_tag_controller against an array-based cache model.
module tb_l2_tag_controller;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic        ack;
    logic [7:0]  hit_group;
    logic        busy;
    logic        err;
    logic        ld_rtrig;
    logic        ld_wtrig;
    logic [31:0] ld_addr;
    logic [7:0]  ld_group;
    logic        ld_finish;
    logic        ld_fault;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    l2_tag_controller dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .ack        (ack),
        .hit_group  (hit_group),
        .busy       (busy),
        .err        (err),
        .ld_rtrig   (ld_rtrig),
        .ld_wtrig   (ld_wtrig),
        .ld_addr    (ld_addr),
        .ld_group   (ld_group),
        .ld_finish  (ld_finish),
        .ld_fault   (ld_fault),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wb;
        logic [31:0] a;
        logic [7:0]  g;
    } trig_t;

    int checks = 0;
    int errors = 0;

    // cache model
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [21:0] m_tag   [16];
    logic [31:0] m_hits;
    logic [31:0] m_misses;
    trig_t       exp_q[$];
    logic [7:0]  exp_hg;

    // observations from the last access, used for literal expectations
    int          nr, nw;
    bit          first_w;
    logic [31:0] last_w_addr, last_r_addr;
    logic [7:0]  last_r_group, last_hg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_hits();
`ifdef L2_TAG_STATS_EN
        return m_hits;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_misses();
`ifdef L2_TAG_STATS_EN
        return m_misses;
`else
        return 32'd0;
`endif
    endfunction

    // per-cycle compare: trigger contents, hold stability, ack-cycle outputs
    bit          outstanding = 0;
    logic [31:0] hold_a;
    logic [7:0]  hold_g;
    always @(negedge clk) begin
        trig_t e;
        if (!reset) begin
            outstanding = 0;
        end else begin
            chk("trig_exclusive", {31'b0, ld_wtrig & ld_rtrig}, 32'd0);
            if (ld_wtrig || ld_rtrig) begin
                chk("trig_single_outstanding", {31'b0, outstanding}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trig: got w=%0b r=%0b addr %h expected no trigger", ld_wtrig, ld_rtrig, ld_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("trig_kind_wb", {31'b0, ld_wtrig}, {31'b0, e.wb});
                    chk("trig_ld_addr", ld_addr, e.a);
                    chk("trig_ld_group", {24'b0, ld_group}, {24'b0, e.g});
                end
                hold_a      = ld_addr;
                hold_g      = ld_group;
                outstanding = 1;
            end else if (outstanding) begin
                chk("hold_ld_addr", ld_addr, hold_a);
                chk("hold_ld_group", {24'b0, ld_group}, {24'b0, hold_g});
                if (ld_finish) outstanding = 0;
            end
            if (ack) begin
                chk("ack_hit_group", {24'b0, hit_group}, {24'b0, exp_hg});
                chk("ack_no_err", {31'b0, err}, 32'd0);
                chk("ack_hit_count", hit_count, exp_hits());
                chk("ack_miss_count", miss_count, exp_misses());
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b0;
        req       = 1'b0;
        ld_finish = 1'b0;
        ld_fault  = 1'b0;
        #2;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_rtrig", {31'b0, ld_rtrig}, 32'd0);
        chk("rst_wtrig", {31'b0, ld_wtrig}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ld_addr", ld_addr, 32'd0);
        chk("rst_ld_group", {24'b0, ld_group}, 32'd0);
        chk("rst_hit_group", {24'b0, hit_group}, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = '0;
        end
        m_hits   = '0;
        m_misses = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // mode 0: normal access; 1: loader fault during refill wait; 2: reset during refill wait
    task automatic access(input logic w, input logic [31:0] a, input int mode);
        logic [3:0]  idx;
        logic [21:0] tg;
        bit          hit, got_ack, any_trig, faulted, fin_wb;
        int          n, fin, fin_n;
        idx = a[9:6];
        tg  = a[31:10];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        nr = 0; nw = 0; first_w = 0;
        if (hit) begin
            m_hits++;
            if (w) m_dirty[idx] = 1;
        end else begin
            m_misses++;
            if (m_valid[idx] && m_dirty[idx])
                exp_q.push_back('{1'b1, {m_tag[idx], idx, 6'h0}, {idx, 4'h0}});
            exp_q.push_back('{1'b0, {a[31:6], 6'h0}, {idx, 4'h0}});
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
            m_dirty[idx] = w;
        end
        exp_hg = a[9:2];
        @(posedge clk);
        #1;
        req = 1'b1; we = w; addr = a;
        n = 0; fin = -1; fin_n = -100; fin_wb = 0;
        got_ack = 0; any_trig = 0; faulted = 0;
        while (n < 80 && !got_ack) begin
            @(posedge clk);
            #1;
            n++;
            ld_finish = 1'b0;
            ld_fault  = 1'b0;
            chk("busy_active", {31'b0, busy}, 32'd1);
            if (n == 1) begin
                addr = $urandom;
                we   = 1'($urandom_range(0, 1));
                if (hit) ld_finish = 1'($urandom_range(0, 1));
            end
            if (ld_wtrig || ld_rtrig) begin
                chk("trig_latency", n, any_trig ? fin_n + 1 : 2);
                any_trig = 1;
                fin_wb   = ld_wtrig;
                if (ld_wtrig) begin
                    nw++;
                    last_w_addr = ld_addr;
                    if (nr == 0) first_w = 1;
                end else begin
                    nr++;
                    last_r_addr  = ld_addr;
                    last_r_group = ld_group;
                end
                if (mode == 2 && ld_rtrig) begin
                    @(posedge clk);
                    #1;
                    chk("busy_in_rf_wait", {31'b0, busy}, 32'd1);
                    do_reset();
                    return;
                end
                fin       = $urandom_range(1, 4);
                ld_finish = 1'($urandom_range(0, 1));
            end else if (fin > 0) begin
                fin--;
                if (fin == 0) begin
                    fin = -1;
                    if (mode == 1 && !fin_wb) begin
                        ld_fault = 1'b1;
                        faulted  = 1;
                        break;
                    end
                    ld_finish = 1'b1;
                    fin_n     = n;
                end
            end
            if (ack) begin
                got_ack = 1;
                chk("ack_latency", n, hit ? 2 : fin_n + 2);
                last_hg = hit_group;
                req     = 1'b0;
            end
        end
        if (mode == 1) begin
            chk("fault_injected", {31'b0, faulted}, 32'd1);
            repeat (3) begin
                @(posedge clk);
                #1;
                ld_fault = 1'b0;
                chk("err_set", {31'b0, err}, 32'd1);
                chk("err_busy", {31'b0, busy}, 32'd1);
                chk("err_no_ack", {31'b0, ack}, 32'd0);
            end
            addr = 32'h0000_1240;
            we   = 1'b0;
            req  = 1'b1;
            repeat (8) begin
                @(posedge clk);
                #1;
                chk("err_req_ignored_ack", {31'b0, ack}, 32'd0);
                chk("err_sticky", {31'b0, err}, 32'd1);
            end
            do_reset();
        end else begin
            chk("ack_seen", {31'b0, got_ack}, 32'd1);
            req = 1'b0;
            @(posedge clk);
            #1;
            chk("idle_busy", {31'b0, busy}, 32'd0);
            chk("idle_ack", {31'b0, ack}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [21:0] rt;
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0;
        ld_finish = 1'b0; ld_fault = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // cold read miss
        access(1'b0, 32'h0000_1240, 0);
        chk("r27_nr", nr, 1);
        chk("r27_nw", nw, 0);
        chk("r27_rt_addr", last_r_addr, 32'h0000_1240);
        chk("r27_rt_group", {24'b0, last_r_group}, 32'h90);
        chk("r27_hit_group", {24'b0, last_hg}, 32'h90);

        // read hit in the same line
        access(1'b0, 32'h0000_1244, 0);
        chk("r28_nr", nr, 0);
        chk("r28_hit_group", {24'b0, last_hg}, 32'h91);
`ifdef L2_TAG_STATS_EN
        chk("r28_hit_count", hit_count, 32'd1);
        chk("r28_miss_count", miss_count, 32'd1);
`else
        chk("r28_hit_count", hit_count, 32'd0);
        chk("r28_miss_count", miss_count, 32'd0);
`endif

        // dirty the line, then evict it with a conflicting tag
        access(1'b1, 32'h0000_1248, 0);
        access(1'b0, 32'h0000_2240, 0);
        chk("r29_nw", nw, 1);
        chk("r29_nr", nr, 1);
        chk("r29_wb_first", {31'b0, first_w}, 32'd1);
        chk("r29_wb_addr", last_w_addr, 32'h0000_1240);
        chk("r29_rf_addr", last_r_addr, 32'h0000_2240);

        // random traffic over a few conflicting tags
        repeat (150) begin
            rt = 22'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rt = rt | 22'h3F_FFF0;
            ra = {rt, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63))};
            access(1'($urandom_range(0, 1)), ra, 0);
        end

        // loader fault while waiting for refill
        do_reset();
        access(1'b0, 32'h0000_1240, 1);

        // reset while waiting for refill leaves nothing valid
        access(1'b0, 32'h0000_1240, 0);
        access(1'b0, 32'h0000_5240, 2);
        access(1'b0, 32'h0000_1240, 0);
        chk("r31_miss_after_reset", nr, 1);
        chk("r31_rt_addr", last_r_addr, 32'h0000_1240);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/l2_tag_controller.md
L2_TAG_CONTROLLER -- requirements
Module: l2_tag_controller

Interface
REQ-001 SHALL have ports: clk in 1 (system clock); reset in 1 (asynchronous, active-low reset).
REQ-002 SHALL have ports: req in 1 (access request, held until ack); we in 1 (write access); addr in 32 (physical byte address).
REQ-003 SHALL have ports: ack out 1 (one-cycle done pulse); hit_group out 8 (cache memory word address {addr[9:6],addr[5:2]}); busy out 1 (not IDLE); err out 1 (sticky loader fault).
REQ-004 SHALL have ports: ld_rtrig out 1 (refill trigger pulse); ld_wtrig out 1 (writeback trigger pulse); ld_addr out 32 (line address to loader); ld_group out 8 (cache line base {index,4'h0}).
REQ-005 SHALL have ports: ld_finish in 1 (loader done pulse); ld_fault in 1 (loader watchdog fault).
REQ-006 SHALL have ports: hit_count out 32, miss_count out 32 (statistics, see Configuration).

Function
REQ-007 SHALL be direct-mapped: 16 lines, 64 B each; index = addr[9:6]; tag = addr[31:10]; per-line valid, dirty, 22-bit tag.
REQ-008 SHALL use states IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, UPDATE, RESP, ERR.
REQ-009 IDLE: on req=1, SHALL latch addr and we and go to LOOKUP; req SHALL NOT be sampled in any other state.
REQ-010 LOOKUP hit (valid and tag equal): SHALL go to RESP and set dirty if we=1; ack SHALL assert exactly 2 cycles after the req-sampling edge.
REQ-011 LOOKUP miss with victim valid and dirty: SHALL go to WB_REQ; miss with victim clean or invalid: SHALL go to RF_REQ.
REQ-012 WB_REQ: SHALL drive ld_wtrig=1 for exactly one cycle, ld_addr={victim tag,index,6'h0}, ld_group={index,4'h0}, then go to WB_WAIT.
REQ-013 WB_WAIT: on ld_finish=1 SHALL clear dirty of the victim and go to RF_REQ.
REQ-014 RF_REQ: SHALL drive ld_rtrig=1 for exactly one cycle, ld_addr={addr[31:6],6'h0}, ld_group={index,4'h0}, then go to RF_WAIT.
REQ-015 RF_WAIT: on ld_finish=1 SHALL go to UPDATE; UPDATE SHALL write tag, set valid, set dirty=we, then go to RESP.
REQ-016 RESP: SHALL drive ack=1 for one cycle and return to IDLE.
REQ-017 ld_wtrig and ld_rtrig SHALL never be high in the same cycle; only one trigger SHALL be outstanding at a time.
REQ-018 ld_addr and ld_group SHALL be held stable from the trigger cycle until ld_finish is seen.
REQ-019 hit_group SHALL be registered and SHALL be valid in the ack cycle.
REQ-020 ld_fault=1 in any non-IDLE state SHALL force ERR and set err=1; ERR SHALL be left only by reset; ack SHALL NOT assert in ERR.
REQ-021 ld_finish=1 seen outside WB_WAIT/RF_WAIT SHALL be ignored.
REQ-022 busy SHALL be 0 only in IDLE.

Reset
REQ-023 reset=0 SHALL asynchronously force IDLE; clear all valid and dirty bits and all tags to 0; drive ack, ld_rtrig, ld_wtrig, err, busy to 0; drive ld_addr, ld_group, hit_group, hit_count, miss_count to 0.
REQ-024 Reset during WB_WAIT or RF_WAIT SHALL abandon the operation and leave no line valid.

Configuration
REQ-025 With L2_TAG_STATS_EN defined: hit_count SHALL increment on each LOOKUP hit and miss_count on each LOOKUP miss; both SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 Without L2_TAG_STATS_EN: hit_count and miss_count SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-027 Read addr=32'h0000_1240 after reset -> miss; ld_rtrig pulse, ld_addr=32'h0000_1240, ld_group=8'h90; no ld_wtrig; ack after ld_finish, hit_group=8'h90.
REQ-028 Repeat read addr=32'h0000_1244 -> hit; ack 2 cycles after req; hit_group=8'h91; no trigger; hit_count=1 (stats on).
REQ-029 Write addr=32'h0000_1248, then read 32'h0000_2240 (same index 9) -> ld_wtrig with ld_addr=32'h0000_1240 first; ld_rtrig with 32'h0000_2240 after ld_finish.
REQ-030 ld_fault=1 during RF_WAIT -> err=1, busy=1, no ack; subsequent req ignored until reset=0.
REQ-031 reset=0 mid RF_WAIT, then read 32'h0000_1240 -> miss (ld_rtrig issued), valid was cleared.
REQ-032 Build without L2_TAG_STATS_EN, run REQ-027/028 -> hit_count=miss_count=0 throughout.
